// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// A captured 128-bit state is transformed COLS_PER_CYCLE columns per clock into a result
// register; the finished block is presented on state_out under a valid/ready handshake.
// Byte k of the state is state[127-8k -: 8], row k%4, column k/4, so column c occupies the
// 32-bit slice with column 0 in the most significant word.

module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter bit          INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv_mode,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  // Only 1, 2 or 4 columns per cycle divide the four columns evenly.
  if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column index step and the index of the final BUSY step (wraps back to 0 afterwards).
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastIdx = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e            fsm_q;
  logic [1:0]        col_idx_q;
  logic [3:0][31:0]  src_q;       // captured input, [3] is column 0
  logic              mode_q;      // 1 = inverse transform for the current block
  logic [3:0][31:0]  res_q;       // result columns, written as they are computed
  logic [3:0][31:0]  res_next;
  logic              out_valid_q;
  logic [127:0]      state_out_q;

  // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Transform one column (a0 in bits 31:24). The inverse multiples 9, B, D, E are sums of the
  // x2/x4/x8 xtime chain, so no multiplier or table is needed.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] r  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m3[i] = m2[i] ^ a[i];
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    if (inv) begin
      r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      r[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
      r[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
      r[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
      r[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Transform the columns addressed by col_idx this cycle; other result columns hold.
  always_comb begin
    logic [1:0] cidx;
    res_next = res_q;
    for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
      cidx = col_idx_q + 2'(j);
      // INV_EN folds to 0 when inverse support is removed, pruning the inverse path.
      res_next[2'd3 - cidx] = mix_column(src_q[2'd3 - cidx], INV_EN && mode_q);
    end
  end

  // Ready when idle, or when the finished block is being taken this cycle.
  always_comb begin
    in_ready = (fsm_q == StIdle) || ((fsm_q == StDone) && out_ready);
  end

  assign out_valid = out_valid_q;
  assign state_out = state_out_q;

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= StIdle;
      col_idx_q   <= 2'd0;
      src_q       <= '0;
      mode_q      <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      state_out_q <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            src_q     <= state_in;
            mode_q    <= INV_EN && inv_mode;
            col_idx_q <= 2'd0;
            fsm_q     <= StBusy;
          end
        end
        StBusy: begin
          res_q <= res_next;
          if (col_idx_q == LastIdx) begin
            col_idx_q   <= 2'd0;
            out_valid_q <= 1'b1;
            state_out_q <= res_next;
            fsm_q       <= StDone;
          end else begin
            col_idx_q <= col_idx_q + ColStep;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              // Back-to-back: the next block enters BUSY without an idle bubble.
              src_q     <= state_in;
              mode_q    <= INV_EN && inv_mode;
              col_idx_q <= 2'd0;
              fsm_q     <= StBusy;
            end else begin
              fsm_q <= StIdle;
            end
          end
        end
        default: begin
          fsm_q       <= StIdle;
          col_idx_q   <= 2'd0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: four instances (1, 2, 4 columns per cycle with
// inverse support, and 2 columns per cycle without it) checked against a GF(2^8) matrix model.

module tb_mix_columns_seq;

  localparam logic [127:0] VecA = 128'hdb135345f20a225c01010101d4bf5d30;
  localparam logic [127:0] VecB = 128'h8e4da1bc9fdc589d01010101046681e5;
  localparam int CPC  [4] = '{1, 2, 4, 2};
  localparam bit INVE [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic         inv_mode  [4];
  logic [127:0] state_in  [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] state_out [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .inv_mode(inv_mode[0]), .state_in(state_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .state_out(state_out[0])
  );
  mix_columns_seq #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .inv_mode(inv_mode[1]), .state_in(state_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .state_out(state_out[1])
  );
  mix_columns_seq #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .inv_mode(inv_mode[2]), .state_in(state_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .state_out(state_out[2])
  );
  mix_columns_seq #(.COLS_PER_CYCLE(2), .INV_EN(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .inv_mode(inv_mode[3]), .state_in(state_in[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .state_out(state_out[3])
  );

  // Generic shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  // Circulant matrix product per column: row r uses coefficient base[(k - r) mod 4] on byte k.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[k], base[(k - r + 4) % 4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block through instance d with out_ready low until the result appears.
  task automatic run_block(input int d, input logic [127:0] din, input bit inv,
                           input logic [127:0] expv, input string name);
    logic [127:0] prev;
    int n;
    @(negedge clk);
    prev = state_out[d];
    in_valid[d] = 1'b1; state_in[d] = din; inv_mode[d] = inv; out_ready[d] = 1'b0;
    #1;
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++; $display("FAIL %s accept d%0d: in_ready=%b want 1", name, d, in_ready[d]);
    end
    @(posedge clk); #1;
    // Mode and data changes after acceptance must not matter.
    in_valid[d] = 1'b0; inv_mode[d] = ~inv; state_in[d] = rand128();
    n = 0;
    do begin
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0 || state_out[d] !== prev) begin
        errors++;
        $display("FAIL %s busy d%0d: valid=%b ready=%b out=%h want 0 0 %h",
                 name, d, out_valid[d], in_ready[d], state_out[d], prev);
      end
      @(posedge clk); #1; n++;
    end while (out_valid[d] !== 1'b1 && n < 8);
    checks++;
    if (n != 4 / CPC[d]) begin
      errors++; $display("FAIL %s latency d%0d: got %0d want %0d", name, d, n, 4 / CPC[d]);
    end
    checks++;
    if (state_out[d] !== expv) begin
      errors++; $display("FAIL %s result d%0d: got %h want %h", name, d, state_out[d], expv);
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || state_out[d] !== expv) begin
      errors++;
      $display("FAIL %s drain d%0d: valid=%b ready=%b out=%h want 0 1 %h",
               name, d, out_valid[d], in_ready[d], state_out[d], expv);
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b0; inv_mode[d] = 1'b0; state_in[d] = '0; out_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || state_out[d] !== 128'h0) begin
        errors++;
        $display("FAIL reset d%0d: ready=%b valid=%b out=%h want 1 0 0",
                 d, in_ready[d], out_valid[d], state_out[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward();
    for (int d = 0; d < 4; d++) run_block(d, VecA, 1'b0, VecB, "fwd_vec");
  endtask

  task automatic test_inverse();
    for (int d = 0; d < 3; d++) run_block(d, VecB, 1'b1, VecA, "inv_vec");
    // Without inverse support the forward transform is used regardless of inv_mode.
    run_block(3, VecB, 1'b1, mix_ref(VecB, 1'b0), "inv_disabled");
  endtask

  task automatic test_random_blocks();
    logic [127:0] v;
    bit m;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 3; i++) begin
        v = rand128(); m = 1'($urandom_range(1));
        run_block(d, v, m, mix_ref(v, m && INVE[d]), "rand_block");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a = rand128();
    logic [127:0] b = rand128();
    int n = 0;
    @(negedge clk);
    in_valid[1] = 1'b1; state_in[1] = a; inv_mode[1] = 1'b0; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    while (out_valid[1] !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || state_out[1] !== mix_ref(a, 1'b0)) begin
        errors++;
        $display("FAIL hold cyc%0d: valid=%b ready=%b out=%h want 1 0 %h",
                 i, out_valid[1], in_ready[1], state_out[1], mix_ref(a, 1'b0));
      end
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; state_in[1] = b; inv_mode[1] = 1'b1;
    #1;
    checks++;
    if (in_ready[1] !== 1'b1) begin
      errors++; $display("FAIL b2b ready: in_ready=%b want 1", in_ready[1]);
    end
    @(posedge clk); #1;
    in_valid[1] = 1'b0; inv_mode[1] = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b busy: valid=%b ready=%b want 0 0", out_valid[1], in_ready[1]);
    end
    n = 0;
    while (out_valid[1] !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 2 || state_out[1] !== mix_ref(b, 1'b1)) begin
      errors++;
      $display("FAIL b2b result: lat=%0d out=%h want 2 %h", n, state_out[1], mix_ref(b, 1'b1));
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b1; state_in[0] = rand128(); inv_mode[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || state_out[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b out=%h ready=%b want 0 0 1",
               out_valid[0], state_out[0], in_ready[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (out_valid[0] !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_mid partial: out_valid=1 want 0"); end
    out_ready[0] = 1'b0;
    run_block(0, VecA, 1'b0, VecB, "after_reset");
  endtask

  // Random in_valid/out_ready gaps; a queue of model results checks order and count.
  task automatic stress(input int d, input int nb);
    logic [127:0] q [$];
    logic [127:0] e;
    int sent = 0, got = 0, cyc = 0;
    bit pend = 1'b0;
    while (got < nb && cyc < 20000) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < nb && $urandom_range(2) != 0) begin
          in_valid[d] = 1'b1; state_in[d] = rand128(); inv_mode[d] = 1'($urandom_range(1));
          pend = 1'b1;
        end else begin
          in_valid[d] = 1'b0; state_in[d] = rand128(); inv_mode[d] = 1'($urandom_range(1));
        end
      end
      out_ready[d] = ($urandom_range(3) != 0);
      #1;
      if (out_valid[d] && out_ready[d]) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stress d%0d: unexpected block %h", d, state_out[d]);
        end else begin
          e = q.pop_front();
          if (state_out[d] !== e) begin
            errors++; $display("FAIL stress d%0d blk%0d: got %h want %h", d, got, state_out[d], e);
          end
        end
        got++;
      end
      if (in_valid[d] && in_ready[d]) begin
        q.push_back(mix_ref(state_in[d], inv_mode[d] && INVE[d]));
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (got != nb || q.size() != 0) begin
      errors++; $display("FAIL stress d%0d count: got %0d want %0d", d, got, nb);
    end
    @(negedge clk);
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_stress();
    for (int d = 0; d < 4; d++) stress(d, 250);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_random_blocks();
    test_back_to_back();
    test_reset_mid();
    test_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
